l1b_bus_sequencer: RTL
======================

L1B_BUS_SEQUENCER -- requirements
Module: l1b_bus_sequencer

Interface
REQ-001 SHALL have parameter FAST_HALF, default 2, meaning hsclk cycles per cpu_phi2 half-phase in fast mode (legal 1..8).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning hsclk cycles allowed without a bbc_phi0 edge during a host cycle (legal 16..255).
REQ-003 hsclk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 bbc_phi0  in  1  host 6502 phase-0 clock, asynchronous to hsclk.
REQ-006 cpu_vda, cpu_vpa  in  1 each  65816 valid-address qualifiers.
REQ-007 cpu_rnw  in  1  65816 read/not-write.
REQ-008 host_sel  in  1  decoded: current CPU address targets host bus (stable during cpu_phi2 low).
REQ-009 ram_sel  in  1  decoded: current CPU address targets on-board SRAM.
REQ-010 cpu_phi2  out  1  clock to 65816.
REQ-011 ram_ceb, ram_oeb, ram_web  out  1 each  active-low SRAM strobes.
REQ-012 host_cyc  out  1  high while host address/rnw/data buffers drive the host bus.
REQ-013 lat_en  out  1  one-hsclk pulse latching host read data.
REQ-014 timeout_err  out  1  sticky flag: host cycle aborted by timeout.

Function
REQ-015 bbc_phi0 SHALL pass through a 2-flop synchroniser; edge detect compares stage 2 with a third flop; rise/fall pulses are one hsclk wide.
REQ-016 States: F_LO, F_HI, H_SYNC, H_LO, H_HI; registered, one-hot or binary at implementer's choice.
REQ-017 Half-phase counter SHALL count 0..FAST_HALF-1 in F_LO and F_HI, reloading to 0 on every state change.
REQ-018 F_LO: cpu_phi2=0; at count FAST_HALF-1, if host_sel & (cpu_vda|cpu_vpa) -> H_SYNC, else -> F_HI.
REQ-019 F_HI: cpu_phi2=1; at count FAST_HALF-1 -> F_LO.
REQ-020 H_SYNC: cpu_phi2=0, host_cyc=0; on synchronised phi0 fall -> H_LO.
REQ-021 H_LO: cpu_phi2=0, host_cyc=1; on phi0 rise -> H_HI.
REQ-022 H_HI: cpu_phi2=1, host_cyc=1; on phi0 fall, lat_en=1 for that cycle and -> F_LO (host_cyc=0 next cycle).
REQ-023 Timeout counter SHALL clear on entry to H_SYNC and on every phi0 edge, increment otherwise in H_SYNC/H_LO/H_HI, saturating at 255; reaching TIMEOUT SHALL force -> F_LO, set timeout_err, no lat_en.
REQ-024 timeout_err SHALL clear only on reset.
REQ-025 ram_ceb=0 only in F_HI with ram_sel & (cpu_vda|cpu_vpa); else 1.
REQ-026 ram_oeb=0 when ram_ceb=0 and cpu_rnw=1.
REQ-027 ram_web=0 when ram_ceb=0, cpu_rnw=0 and half-phase count < FAST_HALF-1 (write ends one hsclk before cpu_phi2 falls); when FAST_HALF=1, ram_web=0 for the whole F_HI cycle.
REQ-028 host_sel and ram_sel both high: host_sel SHALL win; SRAM strobes stay inactive for that cycle.
REQ-029 Neither select, or no valid qualifier: fast internal cycle, all strobes inactive.
REQ-030 Simultaneous phi0 edge and timeout in the same cycle: edge SHALL win.
REQ-031 All outputs SHALL be registered (no combinational path from inputs to outputs).

Reset
REQ-032 While reset=1: state=F_LO, counters=0, synchroniser flops=0, cpu_phi2=0, ram_ceb=ram_oeb=ram_web=1, host_cyc=0, lat_en=0, timeout_err=0.
REQ-033 Reset asserted mid host cycle SHALL abort it within one hsclk with no lat_en pulse; first post-reset cycle is F_LO count 0.

Verification
REQ-034 Fast read, FAST_HALF=2, ram_sel=1, rnw=1, vda=1 -> cpu_phi2 period 4 hsclk, ram_ceb=ram_oeb=0 for exactly 2 cycles per period, ram_web=1.
REQ-035 Fast write, FAST_HALF=3 -> ram_ceb=0 for 3 cycles, ram_web=0 for first 2 only.
REQ-036 Host read, hsclk 16 MHz, bbc_phi0 2 MHz -> cpu_phi2 held low until synced phi0 fall, high for 4 hsclk (+-1) aligned to phi0 high, exactly one lat_en, host_cyc deasserts the cycle after it.
REQ-037 Host cycle with bbc_phi0 frozen, TIMEOUT=32 -> return to F_LO 32 cycles after H_SYNC entry, timeout_err=1, lat_en never pulses.
REQ-038 host_sel=ram_sel=1 -> host sequence runs, ram_ceb stays 1 throughout.
REQ-039 Reset pulse during H_HI -> next cycle all outputs at REQ-032 values, no lat_en, timeout_err=0.

Source files
------------

// File: rtl/l1b_bus_sequencer.sv
// Bus-cycle sequencer for a 65816 second processor: generates cpu_phi2 at a fast
// internal rate and stretches host-bus cycles to track the host 6502's phase-0 clock.
module l1b_bus_sequencer #(
  parameter int FAST_HALF = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic hsclk,
  input  logic reset,
  input  logic bbc_phi0,
  input  logic cpu_vda,
  input  logic cpu_vpa,
  input  logic cpu_rnw,
  input  logic host_sel,
  input  logic ram_sel,
  output logic cpu_phi2,
  output logic ram_ceb,
  output logic ram_oeb,
  output logic ram_web,
  output logic host_cyc,
  output logic lat_en,
  output logic timeout_err
);

  typedef enum logic [2:0] {F_LO, F_HI, H_SYNC, H_LO, H_HI} state_t;

  localparam logic [2:0] HALF_LAST = 3'(FAST_HALF - 1);
  localparam logic [7:0] TO_LIMIT  = 8'(TIMEOUT);
  localparam bit         WR_FULL   = (FAST_HALF == 1);

  state_t     state, state_nxt;
  logic [2:0] hp_cnt, hp_cnt_nxt;
  logic [7:0] to_cnt, to_cnt_nxt, to_inc;
  logic       phi0_s1, phi0_s2, phi0_s3;
  logic       phi0_rise, phi0_fall, phi0_edge, phi0_fall_next;
  logic       valid, host_state, to_hit;
  logic       sram_cyc, wr_window;

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    phi0_rise      = phi0_s2 & ~phi0_s3;
    phi0_fall      = ~phi0_s2 & phi0_s3;
    phi0_edge      = phi0_rise | phi0_fall;
    // A fall will be seen by the edge detector on the following cycle.
    phi0_fall_next = phi0_s2 & ~phi0_s1;
    valid          = cpu_vda | cpu_vpa;
    host_state     = (state == H_SYNC) || (state == H_LO) || (state == H_HI);
    to_inc         = (to_cnt == 8'hFF) ? to_cnt : to_cnt + 8'd1;

    state_nxt  = state;
    to_cnt_nxt = to_cnt;
    to_hit     = 1'b0;

    case (state)
      F_LO:    if (hp_cnt == HALF_LAST) state_nxt = (host_sel & valid) ? H_SYNC : F_HI;
      F_HI:    if (hp_cnt == HALF_LAST) state_nxt = F_LO;
      H_SYNC:  if (phi0_fall) state_nxt = H_LO;
      H_LO:    if (phi0_rise) state_nxt = H_HI;
      H_HI:    if (phi0_fall) state_nxt = F_LO;
      default: state_nxt = F_LO;
    endcase

    // A phi0 edge always takes priority over an expiring timeout.
    if (host_state) begin
      if (phi0_edge) begin
        to_cnt_nxt = '0;
      end else begin
        to_cnt_nxt = to_inc;
        if (to_inc >= TO_LIMIT) begin
          to_hit    = 1'b1;
          state_nxt = F_LO;
        end
      end
    end
    if ((state_nxt == H_SYNC) && (state != H_SYNC)) to_cnt_nxt = '0;

    if (state_nxt != state)                     hp_cnt_nxt = '0;
    else if ((state == F_LO) || (state == F_HI)) hp_cnt_nxt = hp_cnt + 3'd1;
    else                                         hp_cnt_nxt = '0;

    // Host selection overrides SRAM selection when both decode true.
    sram_cyc  = (state_nxt == F_HI) & ram_sel & ~host_sel & valid;
    wr_window = WR_FULL || (hp_cnt_nxt < HALF_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge hsclk) begin
    if (reset) begin
      state       <= F_LO;
      hp_cnt      <= '0;
      to_cnt      <= '0;
      phi0_s1     <= 1'b0;
      phi0_s2     <= 1'b0;
      phi0_s3     <= 1'b0;
      cpu_phi2    <= 1'b0;
      ram_ceb     <= 1'b1;
      ram_oeb     <= 1'b1;
      ram_web     <= 1'b1;
      host_cyc    <= 1'b0;
      lat_en      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      hp_cnt      <= hp_cnt_nxt;
      to_cnt      <= to_cnt_nxt;
      phi0_s1     <= bbc_phi0;
      phi0_s2     <= phi0_s1;
      phi0_s3     <= phi0_s2;
      // Outputs are decoded from the next state so they line up with it.
      cpu_phi2    <= (state_nxt == F_HI) || (state_nxt == H_HI);
      ram_ceb     <= ~sram_cyc;
      ram_oeb     <= ~(sram_cyc & cpu_rnw);
      ram_web     <= ~(sram_cyc & ~cpu_rnw & wr_window);
      host_cyc    <= (state_nxt == H_LO) || (state_nxt == H_HI);
      lat_en      <= (state_nxt == H_HI) & phi0_fall_next;
      timeout_err <= timeout_err | to_hit;
    end
  end

endmodule
